// File: rtl/params_pkg.sv
// Shared core-wide widths used by the completion path.
// Latency: n/a (constants only).
// Backpressure: n/a.
package params_pkg;

    localparam int ROB_ENTRY_WIDTH = 6;
    localparam int DATA_WIDTH      = 32;

endpackage : params_pkg

// File: rtl/completion_arbiter_if.sv
// Result-source and ROB-completion bundle for completion_arbiter.
// Latency: n/a (wires only).
// Backpressure: per-source src_ready_o; the ROB side has no ready.
//
// Signals:
//   src_valid_i / src_ready_o              per-source valid/ready handshake
//   src_idx_i / src_data_i / src_excp_i    per-source payload, held until transfer
//   instr_complete_valid_o / _idx_o / _data_o, instr_excp_valid_o
//                                          registered completion to the ROB
//   pending_o                              any result buffered or being completed
// Modports: master = functional-unit side, slave = arbiter side.
interface completion_arbiter_if #(
    parameter int NUM_SRC         = 3,
    parameter int ROB_ENTRY_WIDTH = params_pkg::ROB_ENTRY_WIDTH,
    parameter int DATA_WIDTH      = params_pkg::DATA_WIDTH
);

    logic [NUM_SRC-1:0]                      src_valid_i;
    logic [NUM_SRC-1:0]                      src_ready_o;
    logic [NUM_SRC-1:0][ROB_ENTRY_WIDTH-1:0] src_idx_i;
    logic [NUM_SRC-1:0][DATA_WIDTH-1:0]      src_data_i;
    logic [NUM_SRC-1:0]                      src_excp_i;

    logic                                    instr_complete_valid_o;
    logic [ROB_ENTRY_WIDTH-1:0]              instr_complete_idx_o;
    logic [DATA_WIDTH-1:0]                   instr_complete_data_o;
    logic                                    instr_excp_valid_o;
    logic                                    pending_o;

    modport master (
        output src_valid_i, src_idx_i, src_data_i, src_excp_i,
        input  src_ready_o,
        input  instr_complete_valid_o, instr_complete_idx_o, instr_complete_data_o,
        input  instr_excp_valid_o, pending_o
    );

    modport slave (
        input  src_valid_i, src_idx_i, src_data_i, src_excp_i,
        output src_ready_o,
        output instr_complete_valid_o, instr_complete_idx_o, instr_complete_data_o,
        output instr_excp_valid_o, pending_o
    );

endinterface : completion_arbiter_if

// File: rtl/completion_arbiter.sv
// Generic small FIFO: head/tail pointers plus occupancy count, wraps modulo DEPTH.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: none internally; the owner gates push with count < DEPTH.
//
// Ports: clk_i, rst_i (sync, active-high), push_vld/push_dat, pop_vld,
//        head_dat (current head entry), count (registered occupancy).
module completion_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_vld,
    input  logic [WIDTH-1:0]             push_dat,
    input  logic                         pop_vld,
    output logic [WIDTH-1:0]             head_dat,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    head_q;
    logic [PW-1:0]    tail_q;
    logic [CW-1:0]    count_q;

    // Storage needs no reset: count_q alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (push_vld) begin
            mem_q[tail_q] <= push_dat;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_vld) begin
                tail_q <= tail_q + PW'(1);
            end
            if (pop_vld) begin
                head_q <= head_q + PW'(1);
            end
            unique case ({push_vld, pop_vld})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_dat = mem_q[head_q];
    assign count    = count_q;

endmodule : completion_fifo

// Completion arbiter: per-source FIFOs, round-robin pick, registered ROB completion port.
// Latency: result accepted at the edge ending cycle N completes in cycle N+2 when uncontended.
// Backpressure: src_ready_o[s] = count[s] < SRC_DEPTH (registered); ROB side never stalls.
//
// Ports: clk_i, rst_i (sync, active-high), cif (completion_arbiter_if.slave):
//        source handshakes in, single completion strobe/idx/data/excp out, pending_o.
module completion_arbiter #(
    parameter int NUM_SRC         = 3,
    parameter int SRC_DEPTH       = 2,
    parameter int ROB_ENTRY_WIDTH = params_pkg::ROB_ENTRY_WIDTH,
    parameter int DATA_WIDTH      = params_pkg::DATA_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    completion_arbiter_if.slave  cif
);

    localparam int SW = $clog2(NUM_SRC);
    localparam int CW = $clog2(SRC_DEPTH + 1);

    typedef struct packed {
        logic                       excp;
        logic [DATA_WIDTH-1:0]      data;
        logic [ROB_ENTRY_WIDTH-1:0] idx;
    } entry_t;

    localparam int EW = $bits(entry_t);

    logic [NUM_SRC-1:0] src_ready;
    logic [NUM_SRC-1:0] nonempty;
    logic [NUM_SRC-1:0] push_vld;
    logic [NUM_SRC-1:0] pop_vld;
    logic [CW-1:0]      count    [NUM_SRC];
    entry_t             head_ent [NUM_SRC];

    logic               grant_vld;
    logic [SW-1:0]      grant_src;
    logic [SW-1:0]      cand;

    logic [SW-1:0]      rr_ptr_q;
    logic               out_vld_q;
    entry_t             out_ent_q;

    // ------------------------------------------------------------------
    // Per-source FIFOs
    // ------------------------------------------------------------------
    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        entry_t          in_ent;
        logic [EW-1:0]   head_raw;

        assign in_ent.excp = cif.src_excp_i[s];
        assign in_ent.data = cif.src_data_i[s];
        assign in_ent.idx  = cif.src_idx_i[s];

        // Handshakes are ignored while reset is held.
        assign push_vld[s] = cif.src_valid_i[s] && src_ready[s] && !rst_i;
        assign pop_vld[s]  = grant_vld && (grant_src == SW'(s));

        completion_fifo #(
            .WIDTH (EW),
            .DEPTH (SRC_DEPTH)
        ) u_fifo (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .push_vld (push_vld[s]),
            .push_dat (in_ent),
            .pop_vld  (pop_vld[s]),
            .head_dat (head_raw),
            .count    (count[s])
        );

        assign head_ent[s] = entry_t'(head_raw);
    end

    // Ready comes from the registered count only, so a full FIFO that is
    // popped this cycle still refuses a new result until next cycle.
    always_comb begin
        src_ready = '0;
        nonempty  = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            src_ready[s] = (count[s] < CW'(SRC_DEPTH));
            nonempty[s]  = (count[s] != '0);
        end
    end

    // ------------------------------------------------------------------
    // Round-robin pick: search starts one past the last winner and takes
    // the first non-empty source.
    // ------------------------------------------------------------------
    always_comb begin
        grant_vld = 1'b0;
        grant_src = rr_ptr_q;
        cand      = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand = SW'((int'(rr_ptr_q) + k) % NUM_SRC);
            if (!grant_vld && nonempty[cand]) begin
                grant_vld = 1'b1;
                grant_src = cand;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pointer and completion register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q  <= SW'(NUM_SRC - 1);
            out_vld_q <= 1'b0;
            out_ent_q <= '0;
        end else begin
            out_vld_q <= grant_vld;
            if (grant_vld) begin
                rr_ptr_q  <= grant_src;
                out_ent_q <= head_ent[grant_src];
            end
        end
    end

    assign cif.src_ready_o            = src_ready;
    assign cif.instr_complete_valid_o = out_vld_q;
    assign cif.instr_complete_idx_o   = out_ent_q.idx;
    assign cif.instr_complete_data_o  = out_ent_q.data;
    assign cif.instr_excp_valid_o     = out_ent_q.excp;
    assign cif.pending_o              = (|nonempty) || out_vld_q;

endmodule : completion_arbiter

// File: doc/completion_arbiter.md
Name: completion_arbiter

Overview:
Collects finished results from the execution pipelines and drives the single per-cycle completion port of the reorder buffer (complete valid / ROB index / data / exception). Each source has a small FIFO with a valid/ready handshake. Sources are arbitrated round-robin, and the winner's result is presented on registered outputs. It sits between the functional units (ALU, MUL, MEM) and the ROB's completion write port; the ROB always accepts a completion, so there is no backpressure input.

Parameters:
NUM_SRC, 3, number of result sources (index 0 = ALU, 1 = MUL, 2 = MEM); legal range 2..8.
SRC_DEPTH, 2, entries per source FIFO; power of two, at least 2.
ROB_ENTRY_WIDTH, params_pkg::ROB_ENTRY_WIDTH, width of a ROB index.
DATA_WIDTH, params_pkg::DATA_WIDTH, result data width.

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
rst_i  in  1  reset; synchronous, active-high.
src_valid_i  in  NUM_SRC  per-source result valid.
src_ready_o  out  NUM_SRC  per-source ready; src_ready_o[s] = (count[s] < SRC_DEPTH).
src_idx_i  in  NUM_SRC x ROB_ENTRY_WIDTH  per-source ROB index of the result.
src_data_i  in  NUM_SRC x DATA_WIDTH  per-source result data.
src_excp_i  in  NUM_SRC  per-source exception flag.
instr_complete_valid_o  out  1  completion strobe to the ROB, one cycle per result.
instr_complete_idx_o  out  ROB_ENTRY_WIDTH  ROB index being completed.
instr_complete_data_o  out  DATA_WIDTH  result data.
instr_excp_valid_o  out  1  exception flag for the completed entry.
pending_o  out  1  high while any FIFO is non-empty or instr_complete_valid_o is high.

Behaviour:
- Handshake: a result transfers on a rising edge where src_valid_i[s] && src_ready_o[s]. The source holds idx, data and excp stable until that transfer. src_ready_o depends only on the registered count, so a full FIFO does not accept a result in the same cycle it is popped.
- Per-source FIFO: head/tail pointers plus a count, wrapping modulo SRC_DEPTH. Push and pop in the same cycle leave count unchanged. Entry order is preserved within a source.
- Arbitration runs each cycle over the sources whose FIFO is non-empty. rr_ptr_q holds the last granted source. Search starts at (rr_ptr_q + 1) mod NUM_SRC and grants the first non-empty source. On a grant, rr_ptr_q becomes the granted index and that FIFO's head entry is popped. With no requester, nothing is granted and rr_ptr_q holds.
- Output register: on a grant, the next cycle has instr_complete_valid_o = 1 and idx/data/excp taken from the popped entry. With no grant, valid = 0 next cycle and idx/data/excp hold their previous values (don't-care).
- Latency: a result transferred at the edge ending cycle 0 appears on the outputs in cycle 2 when uncontended. Peak throughput is one completion per cycle. With every source saturated, each source gets one grant every NUM_SRC cycles.
- Fairness: a continuously non-empty source waits at most NUM_SRC-1 grants of other sources.
- No duplicate or ordering check on ROB indices; sources guarantee uniqueness.
- Reset (synchronous, active-high, may assert at any cycle including mid-traffic): all FIFO counts and pointers = 0, rr_ptr_q = NUM_SRC-1 (source 0 wins first), instr_complete_valid_o = 0, idx/data/excp outputs = 0, pending_o = 0. src_ready_o is all ones from the first cycle after reset. Results that were buffered are discarded.
- With rst_i high, handshakes are ignored and no output is produced.

Test Plan:
1. Single result: reset, then src 1 sends idx=5, data=0xDEAD, excp=0 in cycle 0 -> cycle 2 shows instr_complete_valid_o=1, idx=5, data=0xDEAD; valid=0 in cycle 3.
2. Contention: srcs 0, 1, 2 send idx 1, 2, 3 in the same cycle after reset -> valid for 3 consecutive cycles with idx order 1, 2, 3. A second simultaneous burst with idx 4, 5, 6 also yields 4, 5, 6, confirming the rotation wraps from 2 to 0.
3. FIFO full: src 2 holds valid with idx 7, 8, 9 while src 0 and src 1 stream every cycle -> src_ready_o[2]=0 after 2 accepts. idx 9 is accepted only after a pop, and src 2 completes in order 7, 8, 9.
4. Exception passthrough: src 2 sends idx=12, excp=1, data=0 -> instr_excp_valid_o=1 with idx=12. The next completion has instr_excp_valid_o=0.
5. Reset mid-operation: with 4 entries buffered, assert rst_i for 1 cycle -> no completions follow, pending_o=0, src_ready_o all ones. The next result from src 0 completes 2 cycles later.
6. Back-to-back single source: src 0 streams idx 0..7 every cycle -> eight consecutive completions idx 0..7 starting cycle 2, with no bubbles and src_ready_o[0] never low.
